ts_input_arbiter: RTL and testbench
===================================

// Module: ts_input_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter that merges NUM_QUEUES first-word-fall-through
//  input queues (MAC/CPU rx queues) onto the single user-datapath output bus.
//  Sits at the head of the timestamp pipeline. Drives state/out_*/eop to the
//  in_arb register block for debug and packet counting.
// PARAMETERS
//  DATA_WIDTH   64             datapath word width
//  CTRL_WIDTH   DATA_WIDTH/8   ctrl word width
//  NUM_QUEUES   8              number of input queues (2..16)
//  QID_WIDTH    log2(NUM_QUEUES)  derived; width of queue index
// PORTS
//  clk        in   1                     datapath clock, all logic on rising edge
//  reset      in   1                     asynchronous, active-low (0 = in reset)
//  in_data    in   NUM_QUEUES*DATA_WIDTH queue i word at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_ctrl    in   NUM_QUEUES*CTRL_WIDTH queue i ctrl at [i*CTRL_WIDTH +: CTRL_WIDTH]
//  in_empty   in   NUM_QUEUES            queue i has no word; data/ctrl valid when 0
//  in_rd_en   out  NUM_QUEUES            pop queue i this cycle (combinational)
//  out_data   out  DATA_WIDTH            output word
//  out_ctrl   out  CTRL_WIDTH            output ctrl
//  out_wr     out  1                     out_data/out_ctrl valid this cycle
//  out_rdy    in   1                     downstream can accept a word next cycle
//  state      out  3                     FSM state, for register readback
//  cur_queue  out  QID_WIDTH             currently granted queue
//  eop        out  1                     1-cycle pulse coincident with last word's out_wr
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, rr_ptr=0, cur_queue=0, out_wr=0, eop=0,
//   out_data=0, out_ctrl=0; in_rd_en=0 while in reset. Released synchronously.
//  Packet format: 0+ module-header words (ctrl!=0), then payload words (ctrl==0),
//   terminated by the first word with ctrl!=0 after a ctrl==0 word (the EOP word).
//  FSM (state encoding): IDLE=3'd0, HDR=3'd1, PAYLOAD=3'd2; others unused -> IDLE.
//   IDLE: scan rr_ptr, rr_ptr+1, ... (mod NUM_QUEUES) for first !in_empty; if found,
//    latch cur_queue, go HDR. No pop in IDLE (one bubble cycle per packet).
//   HDR: pop = out_rdy && !in_empty[cur_queue]. Popped word with ctrl==0 -> PAYLOAD.
//   PAYLOAD: pop as HDR. Popped word with ctrl!=0 is EOP -> IDLE,
//    rr_ptr <= cur_queue+1 (wraps to 0 at NUM_QUEUES-1).
//  in_rd_en[i] = pop && (i==cur_queue); all other bits 0. At most one bit set.
//  Datapath: on pop, next cycle out_wr=1, out_data/out_ctrl = popped word
//   (latency 1); else out_wr=0, out_data/out_ctrl hold. eop=1 with the EOP word.
//  Backpressure: out_rdy=0 -> no pop, FSM holds; no word lost or duplicated.
//  Underrun: granted queue empty mid-packet -> stall in place; never re-arbitrate
//   until EOP (no interleaving of packets on output).
//  Empty all queues in IDLE: remain IDLE, rr_ptr unchanged.
//  Single requester: back-to-back packets from same queue allowed (1 bubble each).
//  Reset mid-packet: output stops immediately; partial packet abandoned; restart
//   arbitrates from queue 0.
// TESTING
//  1. Reset, all empty -> state=0, out_wr=0, in_rd_en=0 for 100 cycles.
//  2. Q2 holds 1 hdr + 3 payload + EOP(ctrl=0x01), out_rdy=1 -> 5 out_wr words in
//     order, 1-cycle latency, eop high only on 5th, state 0->1->2->0, rr_ptr=3.
//  3. Q0,Q3,Q7 each hold one 4-word packet -> grant order 0,3,7; repeat -> 0,3,7;
//     no interleaving; in_rd_en one-hot.
//  4. Mid-payload drop out_rdy for 7 cycles -> no pops, out_wr=0, state=2 held;
//     resume with next word, total word count exact.
//  5. Q5 goes empty after 2 payload words for 10 cycles while Q1 non-empty -> stay
//     on Q5 until its EOP, then grant Q1.
//  6. Assert reset during PAYLOAD on Q4 -> out_wr/eop/in_rd_en 0 same cycle;
//     after release with Q0,Q4 pending, Q0 granted first.

Source files
------------

// File: rtl/ts_input_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ts_input_arbiter_if
// Description : Bundle of the queue-side and output-side signals of the
//               timestamp-pipeline input arbiter.
//               master = arbiter side, slave = queues/downstream/regs side.
//   in_data   NUM_QUEUES*DATA_WIDTH  queue words, queue i at [i*DATA_WIDTH +:]
//   in_ctrl   NUM_QUEUES*CTRL_WIDTH  queue ctrl,  queue i at [i*CTRL_WIDTH +:]
//   in_empty  NUM_QUEUES             queue i has no word
//   in_rd_en  NUM_QUEUES             pop queue i this cycle
//   out_data / out_ctrl / out_wr     merged output bus
//   out_rdy                          downstream can accept a word next cycle
//   state / cur_queue / eop          debug and packet-count readback
// Revision    : 1.0 - initial release
// ============================================================================
interface ts_input_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 8,
    parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
);
    logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data;
    logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_QUEUES-1:0]            in_empty;
    logic [NUM_QUEUES-1:0]            in_rd_en;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;
    logic [2:0]                       state;
    logic [QID_WIDTH-1:0]             cur_queue;
    logic                             eop;

    modport master (
        input  in_data, in_ctrl, in_empty, out_rdy,
        output in_rd_en, out_data, out_ctrl, out_wr, state, cur_queue, eop
    );

    modport slave (
        output in_data, in_ctrl, in_empty, out_rdy,
        input  in_rd_en, out_data, out_ctrl, out_wr, state, cur_queue, eop
    );
endinterface
`default_nettype wire

// File: rtl/ts_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ts_input_arbiter
// Description : Packet-granular round-robin arbiter merging NUM_QUEUES
//               first-word-fall-through queues onto one output bus.
//               A queue keeps the grant from its first word until its EOP
//               word, so packets are never interleaved on the output.
// Ports       : clk    - datapath clock, rising edge
//               reset  - asynchronous, active-low
//               bus    - ts_input_arbiter_if.master (queues, output, debug)
// Revision    : 1.0 - initial release
// ============================================================================
module ts_input_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 8,
    parameter int QID_WIDTH  = $clog2(NUM_QUEUES)
) (
    input  logic                 clk,
    input  logic                 reset,
    ts_input_arbiter_if.master   bus
);

    localparam int                   c_QW1    = QID_WIDTH + 1;
    localparam logic [c_QW1-1:0]     c_NQ     = c_QW1'(NUM_QUEUES);
    localparam logic [QID_WIDTH-1:0] c_LAST_Q = QID_WIDTH'(NUM_QUEUES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_PAYLOAD = 3'd2
    } state_t;

    state_t                  r_state;
    logic [QID_WIDTH-1:0]    r_rr_ptr;
    logic [QID_WIDTH-1:0]    r_cur_queue;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [CTRL_WIDTH-1:0]   r_out_ctrl;
    logic                    r_out_wr;
    logic                    r_eop;

    logic                    w_found;
    logic [QID_WIDTH-1:0]    w_grant;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [CTRL_WIDTH-1:0]   w_sel_ctrl;
    logic                    w_sel_empty;
    logic                    w_busy;
    logic                    w_pop;
    logic                    w_ctrl_zero;
    logic [QID_WIDTH-1:0]    w_next_ptr;
    logic [NUM_QUEUES-1:0]   w_rd_en;

    // Round-robin scan starting at r_rr_ptr. The loop runs from the farthest
    // offset down to zero so the nearest non-empty queue is the last to win.
    always_comb begin : p_scan
        logic [c_QW1-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_grant = '0;
        for (int j = NUM_QUEUES - 1; j >= 0; j--) begin
            v_idx = {1'b0, r_rr_ptr} + c_QW1'(j);
            if (v_idx >= c_NQ) begin
                v_idx = v_idx - c_NQ;
            end
            if (!bus.in_empty[v_idx[QID_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_grant = v_idx[QID_WIDTH-1:0];
            end
        end
    end

    // Word/ctrl at the head of the granted queue.
    always_comb begin : p_sel
        w_sel_data = '0;
        w_sel_ctrl = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (r_cur_queue == QID_WIDTH'(i)) begin
                w_sel_data = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_ctrl = bus.in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
    end

    assign w_sel_empty = bus.in_empty[r_cur_queue];
    assign w_busy      = (r_state == S_HDR) || (r_state == S_PAYLOAD);
    // Gating with reset keeps the pop low for the whole reset window, even
    // before the asynchronously cleared state has propagated.
    assign w_pop       = reset && w_busy && bus.out_rdy && !w_sel_empty;
    assign w_ctrl_zero = (w_sel_ctrl == '0);
    assign w_next_ptr  = (r_cur_queue == c_LAST_Q) ? '0 : r_cur_queue + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_rd_en
            assign w_rd_en[gi] = w_pop && (r_cur_queue == QID_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cur_queue <= '0;
            r_out_data  <= '0;
            r_out_ctrl  <= '0;
            r_out_wr    <= 1'b0;
            r_eop       <= 1'b0;
        end else begin
            r_out_wr <= w_pop;
            r_eop    <= 1'b0;
            if (w_pop) begin
                r_out_data <= w_sel_data;
                r_out_ctrl <= w_sel_ctrl;
            end
            case (r_state)
                S_IDLE: begin
                    // Grant only; the first pop happens in S_HDR.
                    if (w_found) begin
                        r_cur_queue <= w_grant;
                        r_state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_pop && w_ctrl_zero) begin
                        r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    // First non-zero ctrl after payload closes the packet.
                    if (w_pop && !w_ctrl_zero) begin
                        r_state  <= S_IDLE;
                        r_eop    <= 1'b1;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_rd_en  = w_rd_en;
    assign bus.out_data  = r_out_data;
    assign bus.out_ctrl  = r_out_ctrl;
    assign bus.out_wr    = r_out_wr;
    assign bus.state     = r_state;
    assign bus.cur_queue = r_cur_queue;
    assign bus.eop       = r_eop;

endmodule
`default_nettype wire

// File: tb/tb_ts_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts_input_arbiter
// Description : Directed self-checking bench for ts_input_arbiter. Queue
//               contents are modelled as FWFT queues; expected output words
//               are queued in the hand-determined grant order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_input_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 8;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   n_out       = 0;
    int   base;

    logic [DW-1:0] inq_d [NQ][$];
    logic [CW-1:0] inq_c [NQ][$];
    logic [DW-1:0] exp_d [$];
    logic [CW-1:0] exp_c [$];
    logic          exp_e [$];

    logic [2:0] st_seq  [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};
    logic       wr_seq  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eop_seq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    ts_input_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) bus ();

    ts_input_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] wd(input int q, input int p, input int w);
        return {16'hC0DE, 16'(q), 16'(p), 16'(w)};
    endfunction

    function automatic logic [CW-1:0] wc(input int nh, input int np, input int w,
                                         input logic [CW-1:0] eopc);
        if (w < nh)           return 8'hFF;
        else if (w < nh + np) return 8'h00;
        else                  return eopc;
    endfunction

    // Word w of a packet: 0..nh-1 header, nh..nh+np-1 payload, nh+np EOP.
    task automatic push_in(input int q, input int p, input int nh, input int np,
                           input logic [CW-1:0] eopc, input int first, input int last);
        for (int w = first; w <= last; w++) begin
            inq_d[q].push_back(wd(q, p, w));
            inq_c[q].push_back(wc(nh, np, w, eopc));
        end
    endtask

    task automatic exp_pkt(input int q, input int p, input int nh, input int np,
                           input logic [CW-1:0] eopc);
        for (int w = 0; w <= nh + np; w++) begin
            exp_d.push_back(wd(q, p, w));
            exp_c.push_back(wc(nh, np, w, eopc));
            exp_e.push_back(w == nh + np);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NQ; i++) begin
            if (inq_d[i].size() != 0) begin
                bus.in_data[i*DW +: DW] = inq_d[i][0];
                bus.in_ctrl[i*CW +: CW] = inq_c[i][0];
                bus.in_empty[i]         = 1'b0;
            end else begin
                bus.in_data[i*DW +: DW] = '0;
                bus.in_ctrl[i*CW +: CW] = '0;
                bus.in_empty[i]         = 1'b1;
            end
        end
    endtask

    // One clock: check the output bus at the falling edge, note which queue
    // the DUT pops at the next rising edge, then update the queue model.
    task automatic tick();
        logic [NQ-1:0] rd;
        @(negedge clk);
        check("rd_en_onehot0", 64'($onehot0(bus.in_rd_en)), 64'd1);
        if (bus.out_wr === 1'b1) begin
            if (exp_d.size() == 0) begin
                check("unexpected_word", bus.out_data, 64'hDEAD);
            end else begin
                check("out_data", bus.out_data, exp_d.pop_front());
                check("out_ctrl", 64'(bus.out_ctrl), 64'(exp_c.pop_front()));
                check("out_eop", 64'(bus.eop), 64'(exp_e.pop_front()));
                n_out++;
            end
        end else begin
            check("eop_without_wr", 64'(bus.eop), 64'd0);
        end
        rd = bus.in_rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (rd[i] && inq_d[i].size() != 0) begin
                void'(inq_d[i].pop_front());
                void'(inq_c[i].pop_front());
            end
        end
        apply_inputs();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_d.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(exp_d.size()), 64'd0);
        tick();
        tick();
        check("idle_after_drain", 64'(bus.state), 64'd0);
    endtask

    task automatic wait_words(input int target, input int max);
        int n = 0;
        while (n_out < target && n < max) begin
            tick();
            n++;
        end
        check("wait_words_timeout", 64'(n_out >= target), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"},  64'(bus.state), 64'd0);
        check({tag, "_out_wr"}, 64'(bus.out_wr), 64'd0);
        check({tag, "_eop"},    64'(bus.eop), 64'd0);
        check({tag, "_rd_en"},  64'(bus.in_rd_en), 64'd0);
    endtask

    initial begin
        reset       = 1'b0;
        bus.out_rdy = 1'b1;
        apply_inputs();

        // Reset values, then 100 idle cycles with every queue empty.
        tick();
        tick();
        check_reset_outputs("rst");
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_out_ctrl", 64'(bus.out_ctrl), 64'd0);
        check("rst_cur_queue", 64'(bus.cur_queue), 64'd0);
        reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            check("idle_state", 64'(bus.state), 64'd0);
            check("idle_out_wr", 64'(bus.out_wr), 64'd0);
            check("idle_rd_en", 64'(bus.in_rd_en), 64'd0);
        end

        // Q2: 1 header + 3 payload + EOP(ctrl 0x01); cycle-exact sequence.
        push_in(2, 0, 1, 3, 8'h01, 0, 4);
        exp_pkt(2, 0, 1, 3, 8'h01);
        apply_inputs();
        check("q2_start_state", 64'(bus.state), 64'd0);
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("q2_state_%0d", k), 64'(bus.state), 64'(st_seq[k]));
            check($sformatf("q2_wr_%0d", k), 64'(bus.out_wr), 64'(wr_seq[k]));
            check($sformatf("q2_eop_%0d", k), 64'(bus.eop), 64'(eop_seq[k]));
            if (k == 0) begin
                check("q2_cur_queue", 64'(bus.cur_queue), 64'd2);
                check("q2_first_rd_en", 64'(bus.in_rd_en), 64'h04);
            end
        end
        drain(20);

        // Pointer now 3: with Q2 and Q3 both pending, Q3 goes first.
        push_in(2, 1, 1, 1, 8'h10, 0, 2);
        push_in(3, 0, 1, 1, 8'h20, 0, 2);
        exp_pkt(3, 0, 1, 1, 8'h20);
        exp_pkt(2, 1, 1, 1, 8'h10);
        apply_inputs();
        drain(40);

        // Reset back to pointer 0; Q0,Q3,Q7 -> grants 0,3,7 twice.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_in(0, r, 1, 2, 8'h01, 0, 3);
            push_in(3, r + 2, 1, 2, 8'h02, 0, 3);
            push_in(7, r, 1, 2, 8'h04, 0, 3);
            exp_pkt(0, r, 1, 2, 8'h01);
            exp_pkt(3, r + 2, 1, 2, 8'h02);
            exp_pkt(7, r, 1, 2, 8'h04);
            apply_inputs();
            drain(80);
        end

        // Backpressure mid-payload on Q1 (pointer is 0 -> Q1 granted).
        base = n_out;
        push_in(1, 0, 1, 6, 8'h08, 0, 7);
        exp_pkt(1, 0, 1, 6, 8'h08);
        apply_inputs();
        wait_words(base + 3, 20);
        bus.out_rdy = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            tick();
            check("bp_rd_en", 64'(bus.in_rd_en), 64'd0);
            check("bp_out_wr", 64'(bus.out_wr), 64'd0);
            check("bp_state", 64'(bus.state), 64'd2);
        end
        bus.out_rdy = 1'b1;
        drain(40);
        check("bp_word_count", 64'(n_out - base), 64'd8);

        // Underrun on Q5 (pointer 2 -> Q5 wins over Q1); Q1 waits for EOP.
        base = n_out;
        push_in(5, 0, 1, 4, 8'h80, 0, 2);
        push_in(1, 1, 1, 2, 8'h01, 0, 3);
        exp_pkt(5, 0, 1, 4, 8'h80);
        exp_pkt(1, 1, 1, 2, 8'h01);
        apply_inputs();
        wait_words(base + 3, 20);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("ur_rd_en", 64'(bus.in_rd_en), 64'd0);
            check("ur_state", 64'(bus.state), 64'd2);
            check("ur_cur_queue", 64'(bus.cur_queue), 64'd5);
            check("ur_out_wr", 64'(bus.out_wr), 64'd0);
        end
        push_in(5, 0, 1, 4, 8'h80, 3, 5);
        apply_inputs();
        drain(40);

        // Reset during Q4 payload; afterwards Q0 beats Q4.
        base = n_out;
        push_in(4, 0, 1, 8, 8'h01, 0, 9);
        exp_pkt(4, 0, 1, 8, 8'h01);
        apply_inputs();
        wait_words(base + 3, 20);
        check("pre_reset_out_wr", 64'(bus.out_wr), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_d.delete();
        exp_c.delete();
        exp_e.delete();
        inq_d[4].delete();
        inq_c[4].delete();
        push_in(4, 1, 1, 1, 8'h01, 0, 2);
        push_in(0, 5, 1, 1, 8'h01, 0, 2);
        exp_pkt(0, 5, 1, 1, 8'h01);
        exp_pkt(4, 1, 1, 1, 8'h01);
        apply_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_reset_outputs("inrst");
        end
        reset = 1'b1;
        tick();
        check("post_rst_grant", 64'(bus.cur_queue), 64'd0);
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
